// File: rtl/mcu_control_unit.sv
// mcu_control_unit: fetch/decode/execute sequencer driving the ALU, holding PC, accumulator and flags.
// Define MCU_CTRL_ILLEGAL_TRAP_EN to trap illegal classes into HALT; otherwise they execute as NOP.
module mcu_control_unit #(
  parameter logic [7:0] PC_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  pm_addr,
  input  logic [15:0] pm_data,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  output logic [3:0]  alu_mode,
  output logic        alu_en,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_cflags,
  output logic [7:0]  acc,
  output logic [3:0]  flags,
  output logic        halted,
  output logic        illegal
);
  typedef enum logic [1:0] {FETCH, DECODE, EXEC, HALT} state_t;
  state_t     state_q;
  logic [7:0] pc_q, pc_d, pm_addr_q, acc_q, op1_q, op2_q, imm_q;
  logic [3:0] cls_q, mode_q, flags_q;
  logic       en_q, halted_q;
`ifdef MCU_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  logic trap;
  assign trap = (cls_q >= 4'h5) && (cls_q <= 4'hE);
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif
  // pc_q already holds PC+1 in EXEC, so fall-through needs no extra add
  assign pc_d = (cls_q == 4'h1 || (cls_q == 4'h2 && flags_q[3])) ? imm_q : pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= PC_RESET;
      pm_addr_q <= PC_RESET;
      acc_q     <= 8'h00;
      flags_q   <= 4'h0;
      op1_q     <= 8'h00;
      op2_q     <= 8'h00;
      mode_q    <= 4'h0;
      imm_q     <= 8'h00;
      cls_q     <= 4'h0;
      en_q      <= 1'b0;
      halted_q  <= 1'b0;
`ifdef MCU_CTRL_ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        FETCH: state_q <= run ? DECODE : FETCH;
        DECODE: begin
          cls_q   <= pm_data[15:12];
          imm_q   <= pm_data[7:0];
          pc_q    <= pc_q + 8'd1;
          op1_q   <= acc_q;
          op2_q   <= pm_data[7:0];
          mode_q  <= pm_data[11:8];
          en_q    <= pm_data[15:12] == 4'h3;
          state_q <= EXEC;
        end
        EXEC: begin
          en_q      <= 1'b0;
          pc_q      <= pc_d;
          pm_addr_q <= pc_d;
          if (cls_q == 4'h3) begin
            acc_q   <= alu_out;
            flags_q <= alu_cflags;
          end else if (cls_q == 4'h4) acc_q <= imm_q;
`ifdef MCU_CTRL_ILLEGAL_TRAP_EN
          state_q  <= (cls_q == 4'hF || trap) ? HALT : FETCH;
          halted_q <= cls_q == 4'hF || trap;
          if (trap) illegal_q <= 1'b1;
`else
          state_q  <= (cls_q == 4'hF) ? HALT : FETCH;
          halted_q <= cls_q == 4'hF;
`endif
        end
        default: state_q <= HALT;
      endcase
    end
  end
  assign pm_addr  = pm_addr_q;
  assign alu_op1  = op1_q;
  assign alu_op2  = op2_q;
  assign alu_mode = mode_q;
  assign alu_en   = en_q;
  assign acc      = acc_q;
  assign flags    = flags_q;
  assign halted   = halted_q;
endmodule

// File: doc/mcu_control_unit.md
# mcu_control_unit

Fetch/decode/execute sequencer for the 8-bit microcontroller, sitting directly upstream of the ALU. It reads 16-bit instructions from a synchronous program memory and holds the 8-bit accumulator and program counter. It drives the ALU's Operand1/Operand2/Mode/E inputs and writes the ALU's Out and CFlags back into the accumulator and flag register. The program counter is internal; the standalone PC adder is not used by this block.

## Interface
- `PC_RESET`, default 8'h00: program counter value after reset.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: fetch enable. Sampled in FETCH only.
- `pm_addr`, output, 8: program memory address.
- `pm_data`, input, 16: program memory read data, valid the cycle after `pm_addr`.
- `alu_op1`, output, 8: ALU Operand1 (accumulator snapshot).
- `alu_op2`, output, 8: ALU Operand2 (immediate).
- `alu_mode`, output, 4: ALU Mode.
- `alu_en`, output, 1: ALU E.
- `alu_out`, input, 8: ALU Out.
- `alu_cflags`, input, 4: ALU CFlags, ordered {Z, C, S, V}.
- `acc`, output, 8: accumulator.
- `flags`, output, 4: registered copy of `alu_cflags`.
- `halted`, output, 1: core stopped on HALT.
- `illegal`, output, 1: sticky flag for an illegal opcode.

## Operation
- Instruction format: [15:12] class, [11:8] ALU mode, [7:0] imm/target.
- 0x0 NOP: no architectural change.
- 0x1 JMP: PC <= imm.
- 0x2 JZ: PC <= imm if flags[3] (Z) = 1, else fall through.
- 0x3 ALUI: acc <= ALU(acc, imm, mode); flags <= alu_cflags.
- 0x4 LDI: acc <= imm; flags unchanged.
- 0xF HALT: enter HALT and stay there until reset.
- Classes 0x5–0xE are illegal; handling is set by the configuration macro.
- States: FETCH, DECODE, EXEC, HALT. Reset state is FETCH.
- FETCH -> DECODE when `run` = 1. Otherwise stay in FETCH.
- DECODE -> EXEC always.
- EXEC -> FETCH, or -> HALT for a HALT instruction.
- PC is 8 bits and wraps 0xFF -> 0x00. A JMP/JZ target overrides the increment.
- Reset values:
  - PC = `PC_RESET`, `pm_addr` = `PC_RESET`
  - `acc`, `flags`, `alu_op1`, `alu_op2`, `alu_mode` = 0
  - `alu_en`, `halted`, `illegal` = 0
- Reset asserted mid-instruction aborts it immediately. No partial acc/flag update survives.

## Timing
- Each instruction takes 3 cycles (FETCH, DECODE, EXEC), plus any cycles stalled in FETCH with `run` = 0.
- FETCH: `pm_addr` = PC (registered).
- DECODE edge:
  - IR <= `pm_data`; PC <= PC+1.
  - `alu_op1` <= acc, `alu_op2` <= `pm_data`[7:0], `alu_mode` <= `pm_data`[11:8].
  - `alu_en` <= (class == 0x3).
- EXEC: `alu_en` is high for exactly this one cycle, ALUI only.
- End of EXEC:
  - ALUI: acc/flags capture `alu_out`/`alu_cflags`.
  - JMP/JZ: PC updates.
  - `alu_en` <= 0.
  - `pm_addr` <= next PC.
- The ALU is combinational. `alu_out` must settle within the EXEC cycle.
- `alu_op1/op2/mode` hold their last values outside EXEC. Only `alu_en` qualifies them.
- `run` deasserting during DECODE/EXEC does not stall. The instruction completes, and the stall takes effect in the next FETCH.
- A JZ directly after an ALUI uses the flags written by that ALUI.

## Configuration
- `MCU_CTRL_ILLEGAL_TRAP_EN` defined: an illegal class sets `illegal` = 1 (sticky until reset) and enters HALT with `halted` = 1 at the end of EXEC.
- Macro undefined: an illegal class executes as NOP. `illegal` is tied to 0.

## Test plan
Bench ALU model: mode 0 = add (Z when result is 0); mode 1 = sub.
- Reset then program {LDI 12, ALUI m0 5, HALT}, `run` = 1 -> `acc` = 17. `alu_en` is high for exactly one cycle, with `alu_op1` = 12, `alu_op2` = 5. `halted` = 1 after cycle 9.
- {LDI 5, ALUI m1 5, JZ 0x10} -> `flags`[3] = 1, next `pm_addr` = 0x10. Repeat with imm 4 -> `flags`[3] = 0, `pm_addr` = 0x03.
- `PC_RESET` = 0xFF, word at 0xFF = NOP -> next fetch at `pm_addr` = 0x00 (wrap).
- `run` = 0 for 5 cycles after reset -> `pm_addr` holds 0 and `alu_en` stays 0. Raise `run` -> first DECODE one cycle later.
- `rst_n` pulsed low during the EXEC of an ALUI -> `acc` = 0 and `alu_en` = 0 asynchronously, then a fresh fetch from `PC_RESET`.
- Opcode 0x7 -> with `MCU_CTRL_ILLEGAL_TRAP_EN`: `illegal` = 1 and `halted` = 1. Without it: `illegal` = 0 and the next fetch proceeds at PC+1.
